// File: rtl/uart_buffer_if.sv
// CPU-side FIFO ports and external UART chip pins of uart_buffer, plus a
// debug view of the sequencer state.
interface uart_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_pop;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          tx_push;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [CW-1:0] tx_count;
  logic          tx_drop;
  logic          err_clr;
  logic          bus_req;
  logic          bus_grant;
  logic [7:0]    uart_din;
  logic [7:0]    uart_dout;
  logic          uart_dout_en;
  logic          data_ready;
  logic          tbre;
  logic          tsre;
  logic          rdn;
  logic          wrn;
  logic [2:0]    state;

  // CPU handshake: rx_pop consumes rx_data only while rx_valid is high;
  // tx_push enqueues tx_data only while tx_ready is high (otherwise it is
  // dropped and flagged in tx_drop). Chip bus: strobes only while bus_grant.
  modport slave (
    input  rx_pop, tx_push, tx_data, err_clr, bus_grant, uart_din,
           data_ready, tbre, tsre,
    output rx_data, rx_valid, rx_count, tx_ready, tx_count, tx_drop,
           bus_req, uart_dout, uart_dout_en, rdn, wrn, state
  );

  modport master (
    output rx_pop, tx_push, tx_data, err_clr, bus_grant, uart_din,
           data_ready, tbre, tsre,
    input  rx_data, rx_valid, rx_count, tx_ready, tx_count, tx_drop,
           bus_req, uart_dout, uart_dout_en, rdn, wrn, state
  );
endinterface

// File: rtl/uart_buffer.sv
// RX/TX FIFOs between the CPU and an external UART chip; a sequencer owns
// the shared chip bus and generates the rdn/wrn strobes.
module uart_buffer #(
  parameter int DEPTH    = 16,
  parameter int RD_PULSE = 2,
  parameter int WR_PULSE = 2,
  parameter int GUARD    = 2
) (
  input  logic clk,
  input  logic rst,
  uart_buffer_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_RD_LOW, ST_RD_DONE,
    ST_WR_SETUP, ST_WR_LOW, ST_WR_HOLD, ST_GUARD
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic          job_rx, job_rx_nx;
  logic [1:0]    dr_q, tbre_q, tsre_q;
  logic          dr_s, tbre_s, tsre_s;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic          rx_full, tx_full, rx_push, rx_push_ok, rx_pop_ok;
  logic          tx_pop, tx_pop_ok, tx_push_ok, tx_drop_q;
  logic [7:0]    rx_byte, dout_q;
  logic          rdn_q, wrn_q, dout_en_q, bus_req_q;
  logic          rx_job, tx_job;

  // The chip status pins are asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_q   <= '0;
      tbre_q <= '0;
      tsre_q <= '0;
    end else begin
      dr_q   <= {dr_q[0], io.data_ready};
      tbre_q <= {tbre_q[0], io.tbre};
      tsre_q <= {tsre_q[0], io.tsre};
    end
  end
  assign dr_s   = dr_q[1];
  assign tbre_s = tbre_q[1];
  assign tsre_s = tsre_q[1];

  assign rx_full    = (rx_cnt == CW'(DEPTH));
  assign tx_full    = (tx_cnt == CW'(DEPTH));
  assign rx_pop_ok  = io.rx_pop && (rx_cnt != '0);
  assign rx_push_ok = rx_push && (!rx_full || rx_pop_ok);
  assign tx_pop_ok  = tx_pop && (tx_cnt != '0);
  assign tx_push_ok = io.tx_push && (!tx_full || tx_pop_ok);

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wp] <= rx_byte;
    if (tx_push_ok) tx_mem[tx_wp] <= io.tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
      if (rx_pop_ok)  rx_rp <= rx_rp + 1'b1;
      if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
      if (tx_pop_ok)  tx_rp <= tx_rp + 1'b1;
      case ({rx_push_ok, rx_pop_ok})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      case ({tx_push_ok, tx_pop_ok})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      // A new overflow outranks a clear arriving in the same cycle.
      if (io.tx_push && tx_full && !tx_pop_ok) tx_drop_q <= 1'b1;
      else if (io.err_clr)                     tx_drop_q <= 1'b0;
    end
  end

  assign rx_job = dr_s && !rx_full;
  assign tx_job = (tx_cnt != '0) && tbre_s && tsre_s;

  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr;
    job_rx_nx = job_rx;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_job) begin
          state_nx  = ST_REQ;
          job_rx_nx = 1'b1;
        end else if (tx_job) begin
          state_nx  = ST_REQ;
          job_rx_nx = 1'b0;
        end
      end
      ST_REQ: begin
        if (io.bus_grant) begin
          if (job_rx) begin
            state_nx = ST_RD_LOW;
            tmr_nx   = TW'(RD_PULSE - 1);
          end else begin
            state_nx = ST_WR_SETUP;
          end
        end
      end
      ST_RD_LOW: begin
        if (tmr == '0) state_nx = ST_RD_DONE;
        else           tmr_nx   = tmr - 1'b1;
      end
      ST_RD_DONE: begin
        rx_push  = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_WR_SETUP: begin
        state_nx = ST_WR_LOW;
        tmr_nx   = TW'(WR_PULSE - 1);
      end
      ST_WR_LOW: begin
        if (tmr == '0) state_nx = ST_WR_HOLD;
        else           tmr_nx   = tmr - 1'b1;
      end
      ST_WR_HOLD: begin
        tx_pop   = 1'b1;
        state_nx = ST_GUARD;
        tmr_nx   = TW'(GUARD - 1);
      end
      ST_GUARD: begin
        if (tmr == '0) state_nx = ST_IDLE;
        else           tmr_nx   = tmr - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      job_rx    <= 1'b0;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      dout_en_q <= 1'b0;
      dout_q    <= '0;
      bus_req_q <= 1'b0;
      rx_byte   <= '0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      job_rx    <= job_rx_nx;
      rdn_q     <= (state_nx != ST_RD_LOW);
      wrn_q     <= (state_nx != ST_WR_LOW);
      dout_en_q <= (state_nx == ST_WR_SETUP) || (state_nx == ST_WR_LOW) ||
                   (state_nx == ST_WR_HOLD);
      bus_req_q <= (state_nx != ST_IDLE);
      if (state_nx == ST_WR_SETUP) dout_q <= tx_mem[tx_rp];
      if ((state == ST_RD_LOW) && (tmr == '0)) rx_byte <= io.uart_din;
    end
  end

  assign io.rx_data      = rx_mem[rx_rp];
  assign io.rx_valid     = (rx_cnt != '0);
  assign io.rx_count     = rx_cnt;
  assign io.tx_ready     = !tx_full;
  assign io.tx_count     = tx_cnt;
  assign io.tx_drop      = tx_drop_q;
  assign io.bus_req      = bus_req_q;
  assign io.uart_dout    = dout_q;
  assign io.uart_dout_en = dout_en_q;
  assign io.rdn          = rdn_q;
  assign io.wrn          = wrn_q;
  assign io.state        = state;
endmodule

// File: tb/tb_uart_buffer.sv
// Directed bench for uart_buffer: reset, RX/TX sequencing, priority, grant
// stall, overflow, RX full back-pressure and pointer wrap.
module tb_uart_buffer;
  localparam int DEPTH = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_RD_LOW = 3'd2,
                         S_RD_DONE = 3'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_buffer_if #(.DEPTH(DEPTH)) io ();
  uart_buffer #(.DEPTH(DEPTH), .RD_PULSE(2), .WR_PULSE(2), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .io(io)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    int k, pulses, sent, started;
    logic prev_rdn, prev_wrn;
    logic [7:0] din, e;

    rst = 1'b0;
    io.rx_pop = 0; io.tx_push = 0; io.tx_data = 0; io.err_clr = 0;
    io.bus_grant = 0; io.uart_din = 0; io.data_ready = 0;
    io.tbre = 0; io.tsre = 0;
    tick(); tick();
    chk("rst_rdn", io.rdn, 1);
    chk("rst_wrn", io.wrn, 1);
    chk("rst_dout_en", io.uart_dout_en, 0);
    chk("rst_dout", io.uart_dout, 0);
    chk("rst_bus_req", io.bus_req, 0);
    chk("rst_rx_valid", io.rx_valid, 0);
    chk("rst_tx_ready", io.tx_ready, 1);
    chk("rst_counts", {io.rx_count, io.tx_count}, 0);
    chk("rst_drop", io.tx_drop, 0);
    chk("rst_state", io.state, S_IDLE);
    rst = 1'b1;
    tick(); tick();

    // Single RX: rdn low on the 4th edge after data_ready rises
    io.data_ready = 1; io.uart_din = 8'hA5; io.bus_grant = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rx1_rdn_wait", io.rdn, 1);
    end
    chk("rx1_state_req", io.state, S_REQ);
    chk("rx1_bus_req", io.bus_req, 1);
    tick();
    chk("rx1_rdn_low0", io.rdn, 0);
    chk("rx1_state_rd", io.state, S_RD_LOW);
    io.data_ready = 0;
    tick();
    chk("rx1_rdn_low1", io.rdn, 0);
    tick();
    chk("rx1_rdn_high", io.rdn, 1);
    chk("rx1_not_yet_valid", io.rx_valid, 0);
    chk("rx1_state_done", io.state, S_RD_DONE);
    tick();
    chk("rx1_valid", io.rx_valid, 1);
    chk("rx1_data", io.rx_data, 8'hA5);
    chk("rx1_count", io.rx_count, 1);
    chk("rx1_idle_bus_req", io.bus_req, 0);
    io.rx_pop = 1;
    tick();
    io.rx_pop = 0;
    chk("rx1_pop_valid", io.rx_valid, 0);
    chk("rx1_pop_count", io.rx_count, 0);
    tick(); tick();
    chk("rx1_no_second_read", io.rdn, 1);

    // Reset asserted mid-strobe
    io.data_ready = 1; io.uart_din = 8'h5A;
    for (k = 0; k < 10 && io.rdn !== 1'b0; k++) tick();
    chk("rstmid_reached_rd", io.rdn, 0);
    rst = 1'b0;
    #1;
    chk("rstmid_rdn", io.rdn, 1);
    chk("rstmid_bus_req", io.bus_req, 0);
    chk("rstmid_state", io.state, S_IDLE);
    chk("rstmid_rx_count", io.rx_count, 0);
    io.data_ready = 0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // TX of two bytes
    io.tbre = 1; io.tsre = 1;
    tick(); tick(); tick();
    io.tx_push = 1; io.tx_data = 8'h41;
    tick();
    chk("tx_count1", io.tx_count, 1);
    io.tx_data = 8'h42;
    tick();
    io.tx_push = 0;
    chk("tx_count2", io.tx_count, 2);
    for (int i = 0; i < 13; i++) begin
      logic en_e, wl_e;
      tick();
      en_e = (i <= 3) || (i >= 8 && i <= 11);
      wl_e = (i == 1) || (i == 2) || (i == 9) || (i == 10);
      chk($sformatf("tx_en_%0d", i), io.uart_dout_en, en_e);
      chk($sformatf("tx_wrn_%0d", i), io.wrn, !wl_e);
      chk($sformatf("tx_rdn_%0d", i), io.rdn, 1);
      if (en_e) chk($sformatf("tx_dout_%0d", i), io.uart_dout, (i < 8) ? 8'h41 : 8'h42);
      chk($sformatf("tx_cnt_%0d", i), io.tx_count, (i < 4) ? 2 : (i < 12) ? 1 : 0);
    end
    for (k = 0; k < 10 && io.state !== S_IDLE; k++) tick();

    // RX and TX pending together: read goes first
    io.tbre = 0;
    tick(); tick(); tick();
    io.tx_push = 1; io.tx_data = 8'h55;
    tick();
    io.tx_push = 0;
    io.data_ready = 1; io.uart_din = 8'h77; io.tbre = 1;
    for (k = 0; k < 20 && io.rdn !== 1'b0 && io.wrn !== 1'b0; k++) tick();
    chk("prio_rdn_first", io.rdn, 0);
    chk("prio_wrn_high", io.wrn, 1);
    io.data_ready = 0;
    for (k = 0; k < 30 && io.wrn !== 1'b0; k++) tick();
    chk("prio_wr_seen", io.wrn, 0);
    chk("prio_wr_data", io.uart_dout, 8'h55);
    for (k = 0; k < 20 && (io.state !== S_IDLE || io.tx_count != 0); k++) tick();
    chk("prio_rx_data", io.rx_data, 8'h77);
    io.rx_pop = 1;
    tick();
    io.rx_pop = 0;

    // Grant withheld
    io.bus_grant = 0; io.data_ready = 1; io.uart_din = 8'h33;
    for (k = 0; k < 10 && io.bus_req !== 1'b1; k++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("grant_req_%0d", i), io.bus_req, 1);
      chk($sformatf("grant_strobes_%0d", i), {io.rdn, io.wrn}, 2'b11);
    end
    io.bus_grant = 1;
    for (k = 0; k < 10 && io.rdn !== 1'b0; k++) tick();
    chk("grant_read_after", io.rdn, 0);
    io.data_ready = 0;
    for (k = 0; k < 10 && io.rx_valid !== 1'b1; k++) tick();
    chk("grant_rx_data", io.rx_data, 8'h33);
    io.rx_pop = 1;
    tick();
    io.rx_pop = 0;

    // TX overflow with the chip busy
    io.tbre = 0;
    tick(); tick(); tick();
    exp_q.delete();
    io.tx_push = 1;
    for (int i = 0; i < 17; i++) begin
      io.tx_data = 8'h80 + 8'(i);
      if (i < 16) exp_q.push_back(io.tx_data);
      tick();
      if (i == 15) begin
        chk("ovf_full_count", io.tx_count, 16);
        chk("ovf_ready_low", io.tx_ready, 0);
        chk("ovf_no_drop_yet", io.tx_drop, 0);
      end
    end
    io.tx_push = 0;
    chk("ovf_count_held", io.tx_count, 16);
    chk("ovf_drop_set", io.tx_drop, 1);
    io.err_clr = 1;
    tick();
    chk("ovf_drop_clr", io.tx_drop, 0);
    io.tx_push = 1; io.tx_data = 8'h91;
    tick();
    io.tx_push = 0; io.err_clr = 0;
    chk("ovf_set_beats_clr", io.tx_drop, 1);
    io.err_clr = 1;
    tick();
    io.err_clr = 0;
    chk("ovf_drop_clr2", io.tx_drop, 0);
    io.tbre = 1;
    prev_wrn = 1;
    for (k = 0; k < 400 && (exp_q.size() != 0 || io.state !== S_IDLE); k++) begin
      tick();
      if (io.wrn == 1'b0 && prev_wrn == 1'b1) begin
        if (exp_q.size() == 0) chk("ovf_extra_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ovf_drain_order", io.uart_dout, e);
        end
      end
      prev_wrn = io.wrn;
    end
    chk("ovf_drained", io.tx_count, 0);

    // RX full: chip holds its byte until a slot frees
    io.data_ready = 1; io.uart_din = 8'hC3;
    for (k = 0; k < 300 && io.rx_count != 16; k++) tick();
    chk("rxfull_count", io.rx_count, 16);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (io.rdn == 1'b0) pulses++;
    end
    chk("rxfull_no_read", pulses, 0);
    chk("rxfull_count_held", io.rx_count, 16);
    io.rx_pop = 1;
    tick();
    io.rx_pop = 0;
    chk("rxfull_pop_count", io.rx_count, 15);
    for (k = 0; k < 12 && io.rdn !== 1'b0; k++) tick();
    chk("rxfull_read_resumes", io.rdn, 0);
    io.data_ready = 0;
    for (k = 0; k < 10 && io.rx_count != 16; k++) tick();
    chk("rxfull_refilled", io.rx_count, 16);
    io.rx_pop = 1;
    for (k = 0; k < 40 && io.rx_valid === 1'b1; k++) tick();
    io.rx_pop = 0;
    chk("rxfull_emptied", io.rx_count, 0);

    // 40-byte stream across pointer wrap
    exp_q.delete();
    din = 8'h00; sent = 0; started = 0; prev_rdn = 1;
    io.uart_din = din; io.data_ready = 1;
    for (k = 0; k < 1000 && (sent < 40 || exp_q.size() != 0 || io.rx_valid === 1'b1); k++) begin
      tick();
      if (io.rdn == 1'b0 && prev_rdn == 1'b1) begin
        started++;
        if (started == 40) io.data_ready = 0;
      end
      if (io.rdn == 1'b1 && prev_rdn == 1'b0) begin
        exp_q.push_back(din);
        din = din + 8'd1;
        io.uart_din = din;
        sent++;
      end
      prev_rdn = io.rdn;
      if (io.rx_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("wrap_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("wrap_data_%0d", e), io.rx_data, e);
        end
        io.rx_pop = 1;
      end else begin
        io.rx_pop = 0;
      end
    end
    io.rx_pop = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("wrap_sent", sent, 40);
    chk("wrap_queue_empty", exp_q.size(), 0);
    chk("wrap_rx_empty", io.rx_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
